// File: rtl/bpsk_tx_scheduler.sv
// ---------------------------------------------------------------------------
// bpsk_tx_scheduler
//
// Frame-level controller for the BPSK transmit path. A frame starts when a
// data bit is offered while idle. The controller then:
//   1. primes the sine generator for one cycle,
//   2. sends a fixed preamble, MSB first,
//   3. pulls data bits over a valid/ready handshake, one bit per symbol,
//   4. stops the generator so that its counter is back at 0 when the frame
//      ends.
// Bit 0 is sent as the sine stream and bit 1 as the negated-sine stream. Each
// symbol lasts PERIODS_PER_BIT whole carrier periods. As a result, every
// symbol boundary falls on a carrier period boundary and the phase stays
// continuous.
//
// Parameters:
//   SAMPLE_NUMBER    samples per carrier period (must match the generator)
//   SAMPLE_WIDTH     sample width (must match the generator)
//   PERIODS_PER_BIT  carrier periods per symbol (>= 1)
//   PREAMBLE_BITS    preamble length in symbols (>= 1)
//   PREAMBLE_PATTERN preamble bits, sent MSB first
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset (share it with the generator)
//   bit_valid    data bit available
//   bit_data     data bit (0 -> sine, 1 -> negated sine)
//   bit_last     marks the final bit of the frame
//   bit_ready    a bit is taken this cycle when bit_valid & bit_ready
//   gen_en       generator enable (combinational)
//   sine_in      generator sine_out
//   neg_sine_in  generator neg_sine_out
//   signal_cnt   generator sample counter
//   mod_out      modulated sample (registered)
//   mod_valid    mod_out valid (registered)
//   busy         a frame is in progress
//   underrun     sticky: no bit was offered at a requested boundary
//   sync_err     sticky: the generator counter disagreed with out_idx
// ---------------------------------------------------------------------------
module bpsk_tx_scheduler #(
  parameter int                       SAMPLE_NUMBER    = 256,
  parameter int                       SAMPLE_WIDTH     = 12,
  parameter int                       PERIODS_PER_BIT  = 4,
  parameter int                       PREAMBLE_BITS    = 8,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = 8'b10101010
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             bit_valid,
  input  logic                             bit_data,
  input  logic                             bit_last,
  output logic                             bit_ready,
  output logic                             gen_en,
  input  logic [SAMPLE_WIDTH-1:0]          sine_in,
  input  logic [SAMPLE_WIDTH-1:0]          neg_sine_in,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] signal_cnt,
  output logic [SAMPLE_WIDTH-1:0]          mod_out,
  output logic                             mod_valid,
  output logic                             busy,
  output logic                             underrun,
  output logic                             sync_err
);

  localparam int IDX_W = $clog2(SAMPLE_NUMBER);
  localparam int PER_W = (PERIODS_PER_BIT > 1) ? $clog2(PERIODS_PER_BIT) : 1;
  localparam int PRE_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLE_NUMBER - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS_PER_BIT - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    PREAMBLE,
    DATA
  } state_t;

  state_t state, state_nxt;

  // out_idx is the index of the sample that is on sine_in now. The generator
  // is always one step ahead, so a healthy generator shows out_idx+1.
  logic [IDX_W-1:0]         out_idx;
  logic [IDX_W-1:0]         next_idx;
  logic [PER_W-1:0]         per_cnt;
  logic [PRE_W-1:0]         pre_cnt;
  logic [PREAMBLE_BITS-1:0] pre_sr;
  logic                     cur_sym;
  logic                     last_flag;

  logic sending;
  logic at_boundary;
  logic pre_last;
  logic frame_end;
  logic take_bit;

  // Symbol timing decode.
  // take_bit marks a boundary at which a new data bit is requested. That
  // happens at the end of the last preamble symbol, and at the end of every
  // data symbol until the frame's last bit has been taken.
  always_comb begin
    sending     = (state == PREAMBLE) || (state == DATA);
    next_idx    = (out_idx == IDX_LAST) ? '0 : out_idx + 1'b1;
    at_boundary = sending && (out_idx == IDX_LAST) && (per_cnt == PER_LAST);
    pre_last    = (pre_cnt == PRE_LAST);
    frame_end   = (state == DATA) && last_flag && at_boundary;
    take_bit    = at_boundary &&
                  (((state == PREAMBLE) && pre_last) ||
                   ((state == DATA) && !last_flag));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and generator/handshake controls.
  // In the final symbol of a frame, the generator enable is dropped on the
  // very last sample. The cycle before, the generator counter wrapped to 0,
  // so it now rests at 0, ready for the next frame.
  always_comb begin
    state_nxt = state;
    gen_en    = 1'b0;
    bit_ready = 1'b0;
    case (state)
      IDLE: begin
        if (bit_valid) begin
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        gen_en    = 1'b1;
        state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        gen_en    = 1'b1;
        bit_ready = take_bit;
        if (take_bit) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        gen_en    = !frame_end;
        bit_ready = take_bit;
        if (frame_end) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Sample path, counters and sticky flags.
  // Starting a frame does not consume the offered bit. That bit is taken only
  // at the end of the preamble. A boundary that requests a bit but finds none
  // sends a 0 (sine) symbol. It also sets underrun and keeps requesting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mod_out   <= '0;
      mod_valid <= 1'b0;
      underrun  <= 1'b0;
      sync_err  <= 1'b0;
      out_idx   <= '0;
      per_cnt   <= '0;
      pre_cnt   <= '0;
      pre_sr    <= '0;
      cur_sym   <= 1'b0;
      last_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mod_valid <= 1'b0;
          if (bit_valid) begin
            underrun  <= 1'b0;
            sync_err  <= 1'b0;
            out_idx   <= '0;
            per_cnt   <= '0;
            pre_cnt   <= '0;
            cur_sym   <= PREAMBLE_PATTERN[PREAMBLE_BITS-1];
            pre_sr    <= PREAMBLE_PATTERN << 1;
            last_flag <= 1'b0;
          end
        end
        PRIME: begin
          mod_valid <= 1'b0;
        end
        PREAMBLE, DATA: begin
          mod_out   <= cur_sym ? neg_sine_in : sine_in;
          mod_valid <= 1'b1;
          out_idx   <= next_idx;
          if (out_idx == IDX_LAST) begin
            per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
          end
          if (gen_en && (signal_cnt != next_idx)) begin
            sync_err <= 1'b1;
          end
          if (at_boundary) begin
            if ((state == PREAMBLE) && !pre_last) begin
              cur_sym <= pre_sr[PREAMBLE_BITS-1];
              pre_sr  <= pre_sr << 1;
              pre_cnt <= pre_cnt + 1'b1;
            end else if (take_bit) begin
              if (bit_valid) begin
                cur_sym   <= bit_data;
                last_flag <= bit_last;
              end else begin
                cur_sym  <= 1'b0;
                underrun <= 1'b1;
              end
            end
          end
        end
        default: begin
          mod_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bpsk_tx_scheduler
//
// Bench for bpsk_tx_scheduler, configured with N=8, PPB=2 and the preamble
// 3'b110. A small sine generator model provides the sample streams. Its
// signal_cnt can be skewed on purpose.
//
// The reference model works at frame level. From the cycles elapsed since
// the frame started, it derives the sample number, symbol number and position
// in the symbol. It keeps a queue with one entry per symbol. The entries are
// filled from the preamble and from whatever the handshake delivers at each
// boundary.
// ---------------------------------------------------------------------------
module tb_bpsk_tx_scheduler;

  localparam int N   = 8;
  localparam int W   = 12;
  localparam int PPB = 2;
  localparam int PB  = 3;
  localparam logic [PB-1:0] PAT = 3'b110;
  localparam int S   = N * PPB;
  localparam int CW  = $clog2(N);

  logic          clk;
  logic          rst;
  logic          bit_valid;
  logic          bit_data;
  logic          bit_last;
  logic          bit_ready;
  logic          gen_en;
  logic [W-1:0]  sine_in;
  logic [W-1:0]  neg_sine_in;
  logic [CW-1:0] signal_cnt;
  logic [W-1:0]  mod_out;
  logic          mod_valid;
  logic          busy;
  logic          underrun;
  logic          sync_err;

  logic [CW-1:0] gen_cnt;
  logic [CW-1:0] cnt_skew;
  logic [PB-1:0] pat_v = PAT;

  int total = 0;
  int bad   = 0;

  // Model and monitor state.
  int          cyc = 0;
  int          m_t = 0;
  int          m_s, m_j, m_p, m_idx;
  bit          m_fin, m_lastsym;
  bit          sym_val[$];
  bit          sym_last[$];
  logic        e_busy, e_gen_en, e_bit_ready, e_mod_valid, e_underrun, e_sync_err;
  logic [W-1:0] e_mod_out;
  logic [W-1:0] samp_log[$];
  int          ready_cnt = 0;
  int          start_cyc = 0;
  int          rise_cyc  = 0;
  logic        prev_mv   = 1'b0;

  bpsk_tx_scheduler #(
    .SAMPLE_NUMBER   (N),
    .SAMPLE_WIDTH    (W),
    .PERIODS_PER_BIT (PPB),
    .PREAMBLE_BITS   (PB),
    .PREAMBLE_PATTERN(PAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .bit_last   (bit_last),
    .bit_ready  (bit_ready),
    .gen_en     (gen_en),
    .sine_in    (sine_in),
    .neg_sine_in(neg_sine_in),
    .signal_cnt (signal_cnt),
    .mod_out    (mod_out),
    .mod_valid  (mod_valid),
    .busy       (busy),
    .underrun   (underrun),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The sample values are distinct for every index, and the sine and
  // negated-sine values never overlap.
  function automatic logic [W-1:0] sine_at(input int k);
    return W'(768 + k * 97);
  endfunction

  function automatic logic [W-1:0] neg_at(input int k);
    return W'(3072 - k * 53);
  endfunction

  // Generator: the sample for cnt=k appears one cycle after en with cnt=k.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gen_cnt     <= '0;
      sine_in     <= '0;
      neg_sine_in <= '0;
    end else if (gen_en) begin
      sine_in     <= sine_at(int'(gen_cnt));
      neg_sine_in <= neg_at(int'(gen_cnt));
      gen_cnt     <= gen_cnt + 1'b1;
    end
  end

  assign signal_cnt = gen_cnt + cnt_skew;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic d, input logic l);
    bit_valid = v;
    bit_data  = d;
    bit_last  = l;
  endtask

  // Reference model and per-cycle compare, at the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      m_t         = 0;
      e_mod_valid = 1'b0;
      e_mod_out   = '0;
      e_underrun  = 1'b0;
      e_sync_err  = 1'b0;
    end
    m_s = 0; m_j = 0; m_p = 0; m_idx = 0; m_fin = 1'b0; m_lastsym = 1'b0;
    if (m_t >= 2) begin
      m_s       = m_t - 2;
      m_j       = m_s / S;
      m_p       = m_s % S;
      m_idx     = m_p % N;
      m_lastsym = (m_j >= PB) ? sym_last[m_j] : 1'b0;
      m_fin     = m_lastsym && (m_p == S - 1);
    end
    e_busy      = (m_t > 0);
    e_gen_en    = (m_t == 1) || ((m_t >= 2) && !m_fin);
    e_bit_ready = (m_t >= 2) && (m_p == S - 1) && (m_j >= PB - 1) && !m_lastsym;

    checkOutput("busy", busy, e_busy);
    checkOutput("gen_en", gen_en, e_gen_en);
    checkOutput("bit_ready", bit_ready, e_bit_ready);
    checkOutput("mod_valid", mod_valid, e_mod_valid);
    if (e_mod_valid || !rst) checkOutput("mod_out", mod_out, e_mod_out);
    checkOutput("underrun", underrun, e_underrun);
    checkOutput("sync_err", sync_err, e_sync_err);
    if (m_t <= 1) checkOutput("gen_cnt_rest", gen_cnt, 0);

    if (mod_valid) samp_log.push_back(mod_out);
    if (mod_valid && !prev_mv) rise_cyc = cyc;
    prev_mv = mod_valid;
    if (bit_ready) ready_cnt++;

    if (rst) begin
      if (m_t == 0) begin
        e_mod_valid = 1'b0;
        if (bit_valid) begin
          start_cyc  = cyc;
          m_t        = 1;
          e_underrun = 1'b0;
          e_sync_err = 1'b0;
          sym_val.delete();
          sym_last.delete();
          for (int i = 0; i < PB; i++) begin
            sym_val.push_back(pat_v[PB-1-i]);
            sym_last.push_back(1'b0);
          end
        end
      end else if (m_t == 1) begin
        e_mod_valid = 1'b0;
        m_t         = 2;
      end else begin
        e_mod_valid = 1'b1;
        e_mod_out   = sym_val[m_j] ? neg_at(m_idx) : sine_at(m_idx);
        if (e_gen_en && (cnt_skew != '0)) e_sync_err = 1'b1;
        if (e_bit_ready) begin
          sym_val.push_back(bit_valid ? bit_data : 1'b0);
          sym_last.push_back(bit_valid ? bit_last : 1'b0);
          if (!bit_valid) e_underrun = 1'b1;
        end
        m_t = m_fin ? 0 : m_t + 1;
      end
    end
  end

  task automatic waitIdle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      step();
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: busy still 1 after 4000 cycles, required 0", name);
    end
  endtask

  // One-bit frame carrying data bit 1 (last). Expected values are computed by
  // hand: the symbols are 1,1,0 (preamble) then 1, with 16 samples each.
  task automatic frameOneBit(input string tag);
    int base, rdy0;
    base = samp_log.size();
    rdy0 = ready_cnt;
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitIdle({tag, "_idle"});
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput({tag, "_latency"}, rise_cyc - start_cyc, 3);
    checkOutput({tag, "_len"}, samp_log.size() - base, 64);
    checkOutput({tag, "_ready_once"}, ready_cnt - rdy0, 1);
    checkOutput({tag, "_pre0"}, samp_log[base + 0], 12'hC00);
    checkOutput({tag, "_pre1"}, samp_log[base + S + 4], 12'hB2C);
    checkOutput({tag, "_pre2"}, samp_log[base + 2*S + 3], 12'h423);
    checkOutput({tag, "_data"}, samp_log[base + 3*S + 9], 12'hBCB);
    checkOutput({tag, "_lastsamp"}, samp_log[base + 63], 12'hA8D);
    checkOutput({tag, "_gencnt"}, gen_cnt, 0);
    checkOutput({tag, "_sync"}, sync_err, 0);
  endtask

  // Main stimulus.
  initial begin
    int base, rdy0;
    bit seen;
    rst = 1'b0;
    cnt_skew = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_mod_valid", mod_valid, 0);
    checkOutput("reset_gen_en", gen_en, 0);
    rst = 1'b1;
    step();
    step();

    $display("[TB] directed: single-bit frame");
    frameOneBit("one_bit");

    $display("[TB] directed: underrun at first data boundary");
    base = samp_log.size();
    rdy0 = ready_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      if (bit_ready) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL stall_ready: bit_ready never rose, required 1");
    end
    step();
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitIdle("stall_idle");
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("stall_underrun", underrun, 1);
    checkOutput("stall_len", samp_log.size() - base, 80);
    checkOutput("stall_ready_twice", ready_cnt - rdy0, 2);
    checkOutput("stall_sine_sym", samp_log[base + 3*S + 1], 12'h361);
    checkOutput("stall_neg_sym", samp_log[base + 4*S + 2], 12'hB96);

    $display("[TB] directed: underrun clears on next start");
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    checkOutput("underrun_clear", underrun, 0);
    waitIdle("clear_idle");
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();

    $display("[TB] directed: skewed generator counter");
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (6) step();
    cnt_skew = CW'(1);
    step();
    cnt_skew = '0;
    waitIdle("skew_idle");
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();
    checkOutput("sync_sticky", sync_err, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    checkOutput("sync_clear", sync_err, 0);
    waitIdle("sync_clear_idle");
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();

    $display("[TB] directed: reset mid-DATA");
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (PB * S + 8) step();
    checkOutput("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mod_valid", mod_valid, 0);
    checkOutput("rst_gen_en", gen_en, 0);
    checkOutput("rst_bit_ready", bit_ready, 0);
    checkOutput("rst_mod_out", mod_out, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    frameOneBit("after_reset");

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      step();
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0));
      cnt_skew = ($urandom_range(0, 199) == 0) ? CW'(1) : CW'(0);
    end
    step();
    cnt_skew = '0;
    if (busy) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitIdle("random_drain");
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run not finished by time 1000000, required earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bpsk_tx_scheduler.md
Name: bpsk_tx_scheduler

Overview:
- Frame-level controller for the BPSK transmit path.
- Sequences the sine generator's enable, inserts a fixed preamble, then pulls data bits over a valid/ready handshake and selects the sine or negated-sine sample stream per bit.
- Holds each bit for an integer number of carrier periods, with phase-continuous symbol boundaries.
- Sits between the bit source and the DAC/filter stage, driving the generator's `en` and consuming its `sine_out`, `neg_sine_out` and `signal_cnt`.

Parameters:
- SAMPLE_NUMBER, 256, samples per carrier period; must match the generator.
- SAMPLE_WIDTH, 12, sample width; must match the generator.
- PERIODS_PER_BIT, 4, carrier periods per symbol (>=1).
- PREAMBLE_BITS, 8, preamble length in symbols (>=1).
- PREAMBLE_PATTERN, 8'b10101010, preamble bits, PREAMBLE_BITS wide, sent MSB first.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- bit_valid  in  1  data bit available
- bit_data  in  1  data bit (0 -> sine, 1 -> negated sine)
- bit_last  in  1  accompanies final bit of frame
- bit_ready  out  1  bit accepted this cycle when bit_valid & bit_ready
- gen_en  out  1  generator enable (combinational)
- sine_in  in  SAMPLE_WIDTH  generator sine_out
- neg_sine_in  in  SAMPLE_WIDTH  generator neg_sine_out
- signal_cnt  in  $clog2(SAMPLE_NUMBER)  generator counter
- mod_out  out  SAMPLE_WIDTH  modulated sample (registered)
- mod_valid  out  1  mod_out valid (registered)
- busy  out  1  state != IDLE
- underrun  out  1  sticky; cleared on frame start
- sync_err  out  1  sticky; cleared on frame start

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; mod_out 0, mod_valid 0, bit_ready 0, gen_en 0, underrun 0, sync_err 0, busy 0.
- Generator latency: sample for signal_cnt=k appears on sine_in/neg_sine_in the cycle after gen_en is high with cnt=k.
- Generator outputs are undefined until primed and are ignored in IDLE/PRIME.
- Internal counters:
  - out_idx (0..SAMPLE_NUMBER-1): index of the sample currently on sine_in.
  - per_cnt (0..PERIODS_PER_BIT-1).
  - pre_cnt (0..PREAMBLE_BITS-1).
  - cur_sym, last_flag.
- States:
  - IDLE: gen_en=0, bit_ready=0. bit_valid high -> PRIME; the bit is not consumed. Clear underrun and sync_err; out_idx=per_cnt=pre_cnt=0; cur_sym=PREAMBLE_PATTERN MSB.
  - PRIME (1 cycle): gen_en=1, fetches sample 0 -> PREAMBLE.
  - PREAMBLE: gen_en=1. Each cycle, register mod_out = cur_sym ? neg_sine_in : sine_in and set mod_valid=1; advance out_idx, wrapping at SAMPLE_NUMBER-1 and incrementing per_cnt.
  - Symbol boundary: the cycle with out_idx==N-1 and per_cnt==PPB-1. At a preamble boundary, cur_sym takes the next pattern bit and pre_cnt increments.
  - On the last preamble boundary, bit_ready=1 and the state moves to DATA.
  - DATA: same sample path as PREAMBLE. bit_ready=1 only on boundary cycles while last_flag=0.
- Data bit handshake at a boundary:
  - Accepted bit loads cur_sym, and bit_last loads last_flag.
  - bit_valid low at a boundary: cur_sym=0, underrun=1 sticky, frame continues, and the next boundary requests again.
- Frame end: DATA with last_flag=1, final symbol, out_idx==N-2 is the last gen_en=1 cycle (generator cnt wraps to 0). At out_idx==N-1: gen_en=0, last sample emitted, next state IDLE; mod_valid drops the following cycle.
- The generator is therefore always stopped at cnt=0.
- mod_valid is contiguous for exactly (PREAMBLE_BITS + accepted/underrun symbols) * PPB * SAMPLE_NUMBER cycles.
- Latency: bit_valid rises in IDLE at cycle T -> PRIME T+1 -> first mod_valid at T+3.
- sync_err: set if gen_en=1 and signal_cnt != (out_idx+1) mod SAMPLE_NUMBER, in PREAMBLE/DATA.
- Reset mid-frame: immediate IDLE with outputs at reset values. The generator must share rst so its cnt returns to 0.
- bit_data, bit_last and bit_valid are ignored except in IDLE (start) and on boundary cycles.

Test Plan:
- Reset mid-DATA (PPB=1, N=8), then start a new frame -> all outputs 0 immediately, sync_err stays 0 on the new frame, first mod_valid at start+3.
- N=8, PPB=1, PREAMBLE=2'b10, bits {0,1(last)} -> 32 contiguous mod_valid samples: neg, sine, sine, neg; gen_en drops 1 cycle before the last sample; signal_cnt ends at 0.
- PPB=2, N=8, one bit 1 (last) -> bit_ready high exactly once, at the 16th preamble-final sample; data symbol spans 16 neg_sine samples.
- Stall bit_valid low at the first data boundary, then supply bit 1 (last) -> underrun=1, one sine symbol inserted, then a neg symbol, then frame end; underrun clears on the next start.
- Force signal_cnt off by one during PREAMBLE -> sync_err=1 sticky until the next frame start.
